// File: rtl/axi_line_fill_pkg.sv
// Shared types and helpers for the AXI line-fill requester.
package axi_line_fill_pkg;

    typedef enum logic [1:0] {IDLE, REQ, DATA, RESP} state_e;

    localparam int unsigned DefNumWords    = 4;
    localparam int unsigned LineOffsetBits = $clog2(DefNumWords) + 3;

    typedef logic [DefNumWords-1:0][63:0] line_t;

    // Byte-offset bits covered by one line of num_words 64-bit dwords.
    function automatic int unsigned line_offset_bits(input int unsigned num_words);
        return $clog2(num_words) + 3;
    endfunction

endpackage

// File: rtl/axi_line_fill.sv
// Single-outstanding AXI read requester that fills one cache line (or one dword) and hands it back.
// Optional build macro AXI_LINE_FILL_TIMEOUT_EN adds a grant-to-last-beat abort timer.
module axi_line_fill
    import axi_line_fill_pkg::*;
#(
    parameter int unsigned AxiNumWords   = 4,
    parameter int unsigned AxiIdWidth    = 4,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clr_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [63:0]                    req_addr_i,
    input  logic                           req_single_i,
    input  logic [1:0]                     req_size_i,
    input  logic [AxiIdWidth-1:0]          req_id_i,
    output logic                           resp_valid_o,
    input  logic                           resp_ready_i,
    output logic [AxiNumWords*64-1:0]      resp_data_o,
    output logic                           resp_err_o,
    output logic                           rd_req_o,
    input  logic                           rd_gnt_i,
    output logic [63:0]                    rd_addr_o,
    output logic [$clog2(AxiNumWords)-1:0] rd_blen_o,
    output logic [1:0]                     rd_size_o,
    output logic [AxiIdWidth-1:0]          rd_id_o,
    output logic                           rd_lock_o,
    output logic                           rd_rdy_o,
    input  logic                           rd_valid_i,
    input  logic                           rd_last_i,
    input  logic [63:0]                    rd_data_i,
    input  logic [AxiIdWidth-1:0]          rd_id_i
);

    localparam int unsigned CntW    = $clog2(AxiNumWords);
    localparam int unsigned OffBits = line_offset_bits(AxiNumWords);

    state_e                         state_q, state_d;
    logic [CntW-1:0]                cnt_q, cnt_d;
    logic                           err_q, err_d;
    logic [CntW-1:0]                blen_q;
    logic [AxiIdWidth-1:0]          id_q;
    logic [63:0]                    addr_q;
    logic [1:0]                     size_q;
    logic [AxiNumWords-1:0][63:0]   buf_q;
    logic                           cap_en;
    logic                           beat_en;
    logic                           tmo_hit;

    // Only beats of our own ID while waiting for data land in the buffer; everything else is sunk.
    assign beat_en = (state_q == DATA) && rd_valid_i && (rd_id_i == id_q);

`ifdef AXI_LINE_FILL_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TimeoutCycles);
    logic [TmoW-1:0] tmo_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
        end else if (clr_i || (state_q != DATA)) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TmoW'(1);
        end
    end

    assign tmo_hit = (state_q == DATA) && (tmo_q == TmoW'(TimeoutCycles - 1));
`else
    assign tmo_hit = (TimeoutCycles == 0);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        cap_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    cap_en  = 1'b1;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (rd_gnt_i) state_d = DATA;
            end
            DATA: begin
                if (beat_en) begin
                    cnt_d = cnt_q + CntW'(1);
                    // Early last and missing last are both flagged: last must coincide with the final beat.
                    if (rd_last_i || (cnt_q == blen_q)) begin
                        err_d   = rd_last_i ^ (cnt_q == blen_q);
                        state_d = RESP;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else if (clr_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Request fields and line buffer are pure data: no reset, held until overwritten.
    always_ff @(posedge clk_i) begin
        if (cap_en) begin
            id_q   <= req_id_i;
            addr_q <= req_single_i ? req_addr_i : {req_addr_i[63:OffBits], OffBits'(0)};
            blen_q <= req_single_i ? '0 : CntW'(AxiNumWords - 1);
            size_q <= req_single_i ? req_size_i : 2'd3;
        end
        if (beat_en) begin
            buf_q[cnt_q] <= rd_data_i;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign rd_req_o     = (state_q == REQ);
    assign resp_valid_o = (state_q == RESP);
    assign resp_err_o   = err_q;
    assign resp_data_o  = buf_q;
    assign rd_addr_o    = addr_q;
    assign rd_blen_o    = blen_q;
    assign rd_size_o    = size_q;
    assign rd_id_o      = id_q;
    assign rd_lock_o    = 1'b0;
    assign rd_rdy_o     = 1'b1;

endmodule
